fifo_rd_stream: RTL

- Read-domain controller for the 32 x 8 asynchronous FIFO. It is the reading end of the shared memory.
- Keeps the binary/gray read pointer, synchronises the write-domain gray pointer, and generates registered empty.
- Issues ren/raddr to the FIFO memory and absorbs its 1-cycle read latency in a 2-entry output buffer.
- Presents a valid/ready stream at full throughput.

---
 rtl/fifo_rd_stream_if.sv | 27 ++
 rtl/fifo_rd_stream.sv | 107 ++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// Read-side FIFO bundle: write-pointer input, memory read port, status and the output stream.
// The master is the read controller; the slave is the environment (write domain, memory, consumer).
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 5
);
  logic [WIDTH:0]      wptr_gray;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                ren;
  logic [WIDTH:0]      raddr;
  logic [WIDTH:0]      rptr_gray;
  logic                empty;
  logic [WIDTH:0]      level;
  logic                m_valid;
  logic                m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  wptr_gray, mem_data, m_ready,
    output ren, raddr, rptr_gray, empty, level, m_valid, m_data
  );

  modport slave (
    output wptr_gray, mem_data, m_ready,
    input  ren, raddr, rptr_gray, empty, level, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain controller of the async FIFO: gray pointer sync, registered empty/level,
// memory read issue and a 2-entry skid buffer hiding the memory's 1-cycle read latency.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 5
) (
  input  logic               rclk,
  input  logic               rrst,
  fifo_rd_stream_if.master   bus
);

  if (DEPTH != (1 << WIDTH)) begin : g_depth_check
    $error("fifo_rd_stream: DEPTH must equal 2**WIDTH");
  end

  function automatic logic [WIDTH:0] bin2gray(input logic [WIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
    logic [WIDTH:0] b;
    b[WIDTH] = g[WIDTH];
    for (int i = WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH:0]        rbin_q, rbin_d;
  logic [WIDTH:0]        rgray_q, rgray_d;
  logic [WIDTH:0]        wq1_q, wq1_d;
  logic [WIDTH:0]        wq2_q, wq2_d;
  logic                  empty_q, empty_d;
  logic [WIDTH:0]        level_q, level_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic                  pop;
  logic                  fetch;
  logic [2:0]            fill;
  logic [1:0]            slot;
  logic [WIDTH:0]        rbin_inc;

  always_comb begin
    pop      = (occ_q != 2'd0) && bus.m_ready;
    // Words that will sit in the buffer after this edge; fetch only if one slot stays free
    fill     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fetch    = !empty_q && (fill <= 3'd1);
    rbin_inc = rbin_q + {{WIDTH{1'b0}}, 1'b1};

    rbin_d     = fetch ? rbin_inc : rbin_q;
    rgray_d    = fetch ? bin2gray(rbin_inc) : rgray_q;
    empty_d    = (rgray_d == wq2_q);
    level_d    = gray2bin(wq2_q) - rbin_d;
    wq1_d      = bus.wptr_gray;
    wq2_d      = wq1_q;
    inflight_d = fetch;
    occ_d      = fill[1:0];

    // Head shifts out on pop; the returning word lands in the first free slot after that
    slot   = occ_q - {1'b0, pop};
    buf0_d = pop ? buf1_q : buf0_q;
    buf1_d = buf1_q;
    if (inflight_q) begin
      if (slot == 2'd0) buf0_d = bus.mem_data;
      else              buf1_d = bus.mem_data;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q     <= '0;
      rgray_q    <= '0;
      wq1_q      <= '0;
      wq2_q      <= '0;
      empty_q    <= 1'b1;
      level_q    <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      wq1_q      <= wq1_d;
      wq2_q      <= wq2_d;
      empty_q    <= empty_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign bus.ren       = fetch;
  assign bus.raddr     = rbin_q;
  assign bus.rptr_gray = rgray_q;
  assign bus.empty     = empty_q;
  assign bus.level     = level_q;
  assign bus.m_valid   = (occ_q != 2'd0);
  assign bus.m_data    = buf0_q;

endmodule
